// File: rtl/trigger_out_async.sv
// trigger_out_async: places a clk80-domain trigger request onto the pad at clk400 resolution,
// with programmable width, post-trigger holdoff veto and a saturating dropped-request counter.
`timescale 1ns/1ps
module trigger_out_async #(
  parameter int HOLDOFF = 2,
  parameter int CNT_W   = 8
) (
  input  logic             reset,
  input  logic             clk400,
  input  logic             clk80,
  input  logic             sync,
  input  logic             enable,
  input  logic             trg_req,
  input  logic [3:0]       trg_pos,
  input  logic [3:0]       pulse_width,
  output logic             trigger_out,
  output logic             busy,
  output logic [CNT_W-1:0] dropped_cnt
);
  localparam int VW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
  typedef enum logic [1:0] {IDLE, PEND, PULSE} state_t;
  state_t          r_state, w_next;
  logic            r_req80, r_sync1, r_clear, r_load, r_trig, r_busy;
  logic [3:0]      r_pos80, r_pos_pend, r_poscnt, r_wcnt, w_width;
  logic [VW-1:0]   r_veto;
  logic [CNT_W-1:0] r_drop;
  logic            w_accept, w_fire, w_end, w_drop;
  always_ff @(posedge clk80 or posedge reset)
    if (reset) begin
      r_req80 <= 1'b0;
      r_pos80 <= 4'd0;
    end else if (sync) begin
      r_req80 <= trg_req & enable;
      r_pos80 <= trg_pos > 4'd9 ? 4'd9 : trg_pos;
    end
  // A request at load is lost when a trigger is still in flight or the holdoff is running.
  always_comb begin
    w_width  = pulse_width == 4'd0 ? 4'd1 : pulse_width;
    w_accept = r_state == IDLE && r_load && r_req80 && r_veto == '0;
    w_fire   = r_state == PEND && r_poscnt == r_pos_pend;
    w_end    = r_state == PULSE && r_wcnt == 4'd0;
    w_drop   = r_load && r_req80 && (r_state != IDLE || r_veto != '0);
    w_next   = w_accept ? PEND : w_fire ? PULSE : w_end ? IDLE : r_state;
  end
  always_ff @(posedge clk400 or posedge reset)
    if (reset) begin
      r_sync1    <= 1'b0;
      r_clear    <= 1'b0;
      r_load     <= 1'b0;
      r_poscnt   <= 4'd0;
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_pos_pend <= 4'd0;
      r_wcnt     <= 4'd0;
      r_trig     <= 1'b0;
      r_veto     <= '0;
      r_drop     <= '0;
    end else begin
      r_sync1  <= clk80;
      r_clear  <= sync & clk80 & ~r_sync1;
      r_load   <= r_clear;
      r_poscnt <= r_load ? 4'd0 : r_poscnt + 4'd1;
      r_state  <= w_next;
      r_busy   <= w_next != IDLE;
      if (w_accept) r_pos_pend <= r_pos80;
      r_wcnt   <= w_fire ? w_width - 4'd1 : (r_state == PULSE && r_wcnt != 4'd0) ? r_wcnt - 4'd1 : r_wcnt;
      r_trig   <= w_fire ? 1'b1 : w_end ? 1'b0 : r_trig;
      r_veto   <= w_fire ? VW'(HOLDOFF) : (r_load && r_veto != '0) ? r_veto - VW'(1) : r_veto;
      if (w_drop && r_drop != '1) r_drop <= r_drop + CNT_W'(1);
    end
  assign trigger_out = r_trig;
  assign busy        = r_busy;
  assign dropped_cnt = r_drop;
endmodule

// File: tb/tb_trigger_out_async.sv
// tb_trigger_out_async: vector table for placement/width plus sequences for veto, reset, enable, saturation.
`timescale 1ns/1ps
module tb_trigger_out_async;
  logic reset, clk400, clk80, sync, enable, trg_req;
  logic [3:0] trg_pos, pulse_width;
  logic a_out, a_busy, b_out, b_busy;
  logic [7:0] a_drop, b_drop;
  int cyc = 0, n_chk = 0, n_err = 0;
  int a_rise, a_fall, a_np = 0, b_np = 0;
  logic a_prev = 0, b_prev = 0;
  typedef struct {int pos; int w; int dly; int len;} vec_t;
  vec_t v[14];
  trigger_out_async #(.HOLDOFF(2), .CNT_W(8)) u_a (
    .reset(reset), .clk400(clk400), .clk80(clk80), .sync(sync), .enable(enable),
    .trg_req(trg_req), .trg_pos(trg_pos), .pulse_width(pulse_width),
    .trigger_out(a_out), .busy(a_busy), .dropped_cnt(a_drop));
  trigger_out_async #(.HOLDOFF(0), .CNT_W(8)) u_b (
    .reset(reset), .clk400(clk400), .clk80(clk80), .sync(sync), .enable(enable),
    .trg_req(trg_req), .trg_pos(trg_pos), .pulse_width(pulse_width),
    .trigger_out(b_out), .busy(b_busy), .dropped_cnt(b_drop));
  initial begin
    clk400 = 0;
    forever #1.25 clk400 = ~clk400;
  end
  // clk80 edges trail the matching clk400 edges slightly so clk400 samples the pre-edge level
  initial begin
    clk80 = 0;
    sync = 0;
    #1.35;
    forever begin
      clk80 = 1;
      #0.5 sync = ~sync;
      #5.75 clk80 = 0;
      #6.25;
    end
  end
  always @(posedge clk400) cyc = cyc + 1;
  always @(negedge clk400) begin
    if (a_out && !a_prev) begin a_rise = cyc; a_np++; end
    if (!a_out && a_prev) a_fall = cyc;
    if (b_out && !b_prev) b_np++;
    a_prev = a_out;
    b_prev = b_out;
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic release_reset();
    @(posedge clk80); #1;
    if (sync) begin @(posedge clk80); #1; end
    reset = 0;
  endtask
  task automatic issue(input int p, output int ld);
    @(posedge clk80); #1;
    if (!sync) begin @(posedge clk80); #1; end
    trg_req = 1;
    trg_pos = p[3:0];
    @(posedge clk80);
    ld = cyc + 7;
    #1 trg_req = 0;
  endtask
  initial begin
    int ld, np0, nb0, d0, k;
    v = '{'{0,1,2,1}, '{1,1,3,1}, '{2,1,4,1}, '{3,1,5,1}, '{4,1,6,1},
          '{5,1,7,1}, '{6,1,8,1}, '{7,1,9,1}, '{8,1,10,1}, '{9,1,11,1},
          '{12,1,11,1}, '{5,0,7,1}, '{5,3,7,3}, '{9,15,11,15}};
    reset = 1; enable = 1; trg_req = 0; trg_pos = 0; pulse_width = 1;
    repeat (5) @(negedge clk400);
    chk("rst_out", a_out, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_drop", a_drop, 0);
    release_reset();
    repeat (20) @(negedge clk400);
    for (int i = 0; i < 14; i++) begin
      pulse_width = v[i].w[3:0];
      a_rise = -1; a_fall = -1; np0 = a_np;
      issue(v[i].pos, ld);
      repeat (50) @(negedge clk400);
      chk($sformatf("v%0d_delay", i), a_rise - ld, v[i].dly);
      chk($sformatf("v%0d_width", i), a_fall - a_rise, v[i].len);
      chk($sformatf("v%0d_count", i), a_np - np0, 1);
      chk($sformatf("v%0d_drop", i), a_drop, 0);
    end
    // four back-to-back windows: holdoff keeps only the first and fourth on the vetoed instance
    pulse_width = 5; trg_pos = 2; np0 = a_np; nb0 = b_np;
    @(posedge clk80); #1;
    if (!sync) begin @(posedge clk80); #1; end
    trg_req = 1;
    @(posedge clk80);
    ld = cyc + 7;
    repeat (6) @(posedge clk80);
    #1 trg_req = 0;
    repeat (60) @(negedge clk400);
    chk("veto_count", a_np - np0, 2);
    chk("veto_last_rise", a_rise - ld, 34);
    chk("veto_drop", a_drop, 2);
    chk("noveto_count", b_np - nb0, 4);
    chk("noveto_drop", b_drop, 0);
    // reset mid-pulse
    pulse_width = 15;
    issue(0, ld);
    k = 0;
    while (!a_out && k < 40) begin @(negedge clk400); k++; end
    chk("midpulse_seen", a_out, 1);
    @(negedge clk400);
    chk("midpulse_busy", a_busy, 1);
    reset = 1;
    #0.1;
    chk("midrst_out", a_out, 0);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_drop", a_drop, 0);
    repeat (4) @(negedge clk400);
    release_reset();
    repeat (20) @(negedge clk400);
    pulse_width = 2; a_rise = -1; a_fall = -1; np0 = a_np;
    issue(3, ld);
    repeat (50) @(negedge clk400);
    chk("postrst_delay", a_rise - ld, 5);
    chk("postrst_width", a_fall - a_rise, 2);
    chk("postrst_count", a_np - np0, 1);
    // disabled requests vanish without being counted
    @(posedge clk80); #1;
    enable = 0; trg_req = 1; trg_pos = 0; pulse_width = 1;
    np0 = a_np; nb0 = b_np; d0 = a_drop;
    repeat (60) @(negedge clk400);
    chk("dis_count", a_np - np0, 0);
    chk("dis_count_b", b_np - nb0, 0);
    chk("dis_drop", a_drop, d0);
    @(posedge clk80); #1;
    enable = 1;
    repeat (4800) @(negedge clk400);
    chk("sat_drop", a_drop, 255);
    repeat (300) @(negedge clk400);
    chk("sat_hold", a_drop, 255);
    chk("sat_drop_b", b_drop, 0);
    trg_req = 0;
    repeat (40) @(negedge clk400);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/trigger_out_async.md
Name: trigger_out_async

Overview:
- Transmit-side counterpart of the asynchronous trigger input sampler. Takes a trigger request and a 4-bit sub-bunch position from the clk80/sync (40 MHz window) domain.
- Emits the trigger on the output pin at clk400 resolution: a pulse of programmable width whose rising edge is placed `pos` clk400 cycles into the 10-cycle window.
- Sits between the trigger sequencer (clk80) and the trigger output pad, with drop and veto bookkeeping.

Parameters:
- HOLDOFF, 2, number of 40 MHz windows after an emitted trigger during which new requests are vetoed (0 = no veto).
- CNT_W, 8, width of the dropped-trigger counter.

Ports:
- reset  in  1  asynchronous, active-high, clears all state in both domains
- clk400  in  1  400 MHz clock, phase-aligned to clk80 (same PLL)
- clk80  in  1  80 MHz clock; also sampled as data in clk400 for window alignment
- sync  in  1  clk80-domain strobe, high every second clk80 cycle (40 MHz window marker)
- enable  in  1  clk80-domain; 0 = requests ignored, output held low after current pulse ends
- trg_req  in  1  clk80-domain trigger request, sampled only when sync=1
- trg_pos  in  4  clk80-domain fine position 0..9 in clk400 cycles, sampled with trg_req
- pulse_width  in  4  static config, output pulse width in clk400 cycles (0 treated as 1)
- trigger_out  out  1  registered clk400 output to pad
- busy  out  1  clk400, high while a trigger is pending or the pulse is active
- dropped_cnt  out  CNT_W  clk400, saturating count of requests lost to veto or busy

Behaviour:
- All registers are async reset. Reset values: trigger_out=0, busy=0, dropped_cnt=0. Reset mid-pulse terminates the pulse immediately.
- clk80 capture: on posedge clk80 with sync=1, req80 <= trg_req & enable and pos80 <= min(trg_pos, 9). Both registers are held otherwise. Any trg_pos value of 10..15 is clamped to 9.
- Window alignment (clk400):
  - sync1 <= clk80
  - clear <= sync & clk80 & !sync1
  - load <= clear
  - load marks window cycle 0.
  - req80/pos80 are stable for at least one clk400 cycle before load.
- Fine counter: poscnt <= 0 when load, else poscnt + 1. Width is 4 bits and it wraps freely; it is only compared inside the window.
- State machine, states IDLE, PEND, PULSE:
  - IDLE: on load with req80=1 and veto_cnt=0, latch pos_pend <= pos80 and go to PEND. If req80=1 and veto_cnt!=0, increment dropped_cnt and stay.
  - PEND: when poscnt==pos_pend, go to PULSE with trigger_out <= 1 and wcnt <= max(pulse_width, 1) - 1. trigger_out therefore rises exactly pos+2 clk400 cycles after the load cycle.
  - PULSE: wcnt decrements each cycle. When wcnt==0, trigger_out <= 0 and the block returns to IDLE. Pulse width is exactly max(pulse_width, 1) cycles.
  - A pulse may cross into the next window. If load with req80=1 occurs while in PEND or PULSE, that request is dropped (dropped_cnt +1). The current pulse is never shortened or retriggered.
- Veto:
  - On entry to PULSE, veto_cnt <= HOLDOFF.
  - veto_cnt decrements on each load while nonzero. Decrement and the check for a new request happen on the same load: the check uses the pre-decrement value.
  - Net effect: with HOLDOFF=2, requests in the 2 windows following the trigger window are dropped.
- dropped_cnt saturates at all-ones and never wraps.
- busy = (state != IDLE), registered.
- enable is sampled in clk80 only. Deasserting it never truncates an active pulse.

Test Plan:
- Reset, then one request with trg_pos=0, pulse_width=1 -> trigger_out high exactly 1 cycle, rising 2 clk400 cycles after load. dropped_cnt=0.
- Sweep trg_pos 0..9 (one request every 4 windows, HOLDOFF=2) -> rising edge moves by exactly 1 clk400 per step. trg_pos=12 -> same edge as trg_pos=9.
- pulse_width=0, then 3, then 15 -> pulse lengths 1, 3, 15 cycles. width 15 with pos=9 crosses the window boundary intact.
- Requests in 4 consecutive windows with HOLDOFF=2 -> triggers emitted in windows 0 and 3 only, dropped_cnt=2. Repeat with HOLDOFF=0 and width 5 -> all 4 emitted.
- Assert reset during PULSE -> trigger_out=0 and busy=0 immediately. The next request after release is emitted normally.
- enable=0 with continuous requests -> no pulses, dropped_cnt unchanged. Force 300 busy drops with CNT_W=8 -> dropped_cnt saturates at 255.
